// File: rtl/kernel_pll_reconfig_sequencer_if.sv
// ---------------------------------------------------------------------------
// kernel_pll_reconfig_sequencer_if
// Avalon-MM style word bus between the PLL reconfig sequencer (master) and
// the PLL reconfiguration IP (slave).
//   rcfg_address     [5:0]  word address
//   rcfg_write              write strobe, held until waitrequest is low
//   rcfg_read               read strobe, held until waitrequest is low
//   rcfg_writedata   [31:0] write data
//   rcfg_readdata    [31:0] read data, valid in the cycle waitrequest is low
//   rcfg_waitrequest        slave stall
// ---------------------------------------------------------------------------
interface kernel_pll_reconfig_sequencer_if;
  logic [5:0]  rcfg_address;
  logic        rcfg_write;
  logic        rcfg_read;
  logic [31:0] rcfg_writedata;
  logic [31:0] rcfg_readdata;
  logic        rcfg_waitrequest;

  modport master (
    output rcfg_address, rcfg_write, rcfg_read, rcfg_writedata,
    input  rcfg_readdata, rcfg_waitrequest
  );

  modport slave (
    input  rcfg_address, rcfg_write, rcfg_read, rcfg_writedata,
    output rcfg_readdata, rcfg_waitrequest
  );
endinterface

// File: rtl/kernel_pll_reconfig_sequencer.sv
// ---------------------------------------------------------------------------
// kernel_pll_reconfig_sequencer
// Reprograms a PLL through its reconfiguration IP with a latched profile
// (N, M, fractional M, C0..C(NUM_CLOCKS-1)), starts the reconfig, polls the
// status word until the IP reports completion, then waits for the PLL to
// hold lock for SETTLE_CYCLES before releasing the kernel reset.
//
// Ports
//   clk, resetn           clock, asynchronous active-low reset
//   start_valid/ready     request handshake; ready only while idle
//   prof_n, prof_m        {odd, bypass, hi[7:0], lo[7:0]}
//   prof_frac             fractional M value
//   prof_c                counter i in bits [18i+17:18i]
//   rcfg                  reconfig IP bus (master side)
//   pll_locked            raw, asynchronous PLL lock
//   kernel_resetn         active-low reset for kernel clock consumers
//   busy, done, error     not idle / end-of-sequence pulse / sticky timeout
// ---------------------------------------------------------------------------
module kernel_pll_reconfig_sequencer #(
  parameter int NUM_CLOCKS    = 2,
  parameter int LOCK_TIMEOUT  = 1000000,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       start_valid,
  output logic                       start_ready,
  input  logic [17:0]                prof_n,
  input  logic [17:0]                prof_m,
  input  logic [31:0]                prof_frac,
  input  logic [18*NUM_CLOCKS-1:0]   prof_c,
  kernel_pll_reconfig_sequencer_if.master rcfg,
  input  logic                       pll_locked,
  output logic                       kernel_resetn,
  output logic                       busy,
  output logic                       done,
  output logic                       error
);

  localparam int TMO_W  = $clog2(LOCK_TIMEOUT + 1);
  localparam int STAB_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [4:0]        C_LAST   = 5'(NUM_CLOCKS - 1);
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(SETTLE_CYCLES);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(LOCK_TIMEOUT - 1);

  typedef enum logic [3:0] {
    ST_IDLE, ST_MODE, ST_WR_N, ST_WR_M, ST_WR_FRAC,
    ST_WR_C, ST_START, ST_POLL, ST_WAIT_LOCK
  } state_t;

  state_t state_q, state_nxt;

  logic [17:0]              prof_n_q, prof_m_q;
  logic [31:0]              prof_frac_q;
  logic [18*NUM_CLOCKS-1:0] prof_c_q;

  logic [4:0]        c_idx_q, c_idx_nxt;
  logic [TMO_W-1:0]  tmo_q, tmo_nxt;
  logic [STAB_W-1:0] stab_q, stab_nxt, stab_inc;
  logic              sync_p0, sync_p1;
  logic              lk;

  logic              accept, seq_end, timeout_hit, wr_done, rd_done;
  logic              done_q, error_q, kres_q;

  logic [5:0]  addr_q, addr_nxt;
  logic [31:0] wdata_q, wdata_nxt;
  logic        wr_q, wr_nxt, rd_q, rd_nxt;

  // Only the completion bit of the status word matters.
  logic unused_readdata;
  assign unused_readdata = ^rcfg.rcfg_readdata[31:1];

  function automatic logic [STAB_W-1:0] stab_sat_inc(input logic [STAB_W-1:0] v);
    return (v == STAB_MAX) ? v : v + STAB_W'(1);
  endfunction

  function automatic logic [17:0] c_word(input logic [4:0] idx);
    return prof_c_q[18*int'(idx) +: 18];
  endfunction

  // Stage p0/p1: two-flop synchroniser for the asynchronous lock.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= pll_locked;
      sync_p1 <= sync_p0;
    end
  end
  assign lk = sync_p1;

  assign start_ready = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);

  always_comb begin
    state_nxt   = state_q;
    c_idx_nxt   = c_idx_q;
    tmo_nxt     = tmo_q;
    accept      = 1'b0;
    seq_end     = 1'b0;
    timeout_hit = 1'b0;
    wr_done     = !rcfg.rcfg_waitrequest;
    rd_done     = rd_q && !rcfg.rcfg_waitrequest;
    stab_inc    = lk ? stab_sat_inc(stab_q) : '0;

    case (state_q)
      ST_IDLE: begin
        if (start_valid) begin
          accept    = 1'b1;
          state_nxt = ST_MODE;
        end
      end
      ST_MODE:    if (wr_done) state_nxt = ST_WR_N;
      ST_WR_N:    if (wr_done) state_nxt = ST_WR_M;
      ST_WR_M:    if (wr_done) state_nxt = ST_WR_FRAC;
      ST_WR_FRAC: if (wr_done) state_nxt = ST_WR_C;
      ST_WR_C: begin
        if (wr_done) begin
          if (c_idx_q == C_LAST) begin
            c_idx_nxt = '0;
            state_nxt = ST_START;
          end else begin
            c_idx_nxt = c_idx_q + 5'd1;
          end
        end
      end
      ST_START: begin
        if (wr_done) begin
          tmo_nxt   = '0;
          state_nxt = ST_POLL;
        end
      end
      ST_POLL: begin
        if (tmo_q == TMO_LAST) begin
          timeout_hit = 1'b1;
          state_nxt   = ST_IDLE;
        end else begin
          tmo_nxt = tmo_q + TMO_W'(1);
          if (rd_done && rcfg.rcfg_readdata[0]) state_nxt = ST_WAIT_LOCK;
        end
      end
      ST_WAIT_LOCK: begin
        // A lock that settles on the final allowed cycle still counts as success.
        if (stab_inc == STAB_MAX) begin
          seq_end   = 1'b1;
          state_nxt = ST_IDLE;
        end else if (tmo_q == TMO_LAST) begin
          timeout_hit = 1'b1;
          state_nxt   = ST_IDLE;
        end else begin
          tmo_nxt = tmo_q + TMO_W'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // The settle count restarts on entry so a pre-existing lock is re-qualified.
    stab_nxt = (state_q != ST_WAIT_LOCK && state_nxt == ST_WAIT_LOCK) ? '0 : stab_inc;

    // Bus outputs are registered from the next state so each beat appears in
    // the cycle its state is entered and holds while the state holds.
    addr_nxt  = '0;
    wdata_nxt = '0;
    wr_nxt    = 1'b0;
    rd_nxt    = 1'b0;
    case (state_nxt)
      ST_MODE:    begin wr_nxt = 1'b1; addr_nxt = 6'd0; wdata_nxt = 32'd1; end
      ST_WR_N:    begin wr_nxt = 1'b1; addr_nxt = 6'd3; wdata_nxt = {14'b0, prof_n_q}; end
      ST_WR_M:    begin wr_nxt = 1'b1; addr_nxt = 6'd4; wdata_nxt = {14'b0, prof_m_q}; end
      ST_WR_FRAC: begin wr_nxt = 1'b1; addr_nxt = 6'd7; wdata_nxt = prof_frac_q; end
      ST_WR_C: begin
        wr_nxt    = 1'b1;
        addr_nxt  = 6'd5;
        wdata_nxt = {9'b0, c_idx_nxt, c_word(c_idx_nxt)};
      end
      ST_START:   begin wr_nxt = 1'b1; addr_nxt = 6'd2; wdata_nxt = 32'd1; end
      ST_POLL: begin
        addr_nxt = 6'd1;
        // A not-ready status leaves one idle cycle before the read is re-issued.
        rd_nxt   = !(state_q == ST_POLL && rd_done);
      end
      default: ;
    endcase
  end

  // Stage p0 -> p1: control state and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      c_idx_q <= '0;
      tmo_q   <= '0;
      stab_q  <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      kres_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_nxt;
      c_idx_q <= c_idx_nxt;
      tmo_q   <= tmo_nxt;
      stab_q  <= stab_nxt;
      done_q  <= seq_end || timeout_hit;
      if (accept)           error_q <= 1'b0;
      else if (timeout_hit) error_q <= 1'b1;
      kres_q  <= (state_nxt == ST_IDLE) && (stab_nxt == STAB_MAX);
      addr_q  <= addr_nxt;
      wdata_q <= wdata_nxt;
      wr_q    <= wr_nxt;
      rd_q    <= rd_nxt;
    end
  end

  // Profile capture at the accepting handshake.
  always_ff @(posedge clk) begin
    if (accept) begin
      prof_n_q    <= prof_n;
      prof_m_q    <= prof_m;
      prof_frac_q <= prof_frac;
      prof_c_q    <= prof_c;
    end
  end

  assign rcfg.rcfg_address   = addr_q;
  assign rcfg.rcfg_writedata = wdata_q;
  assign rcfg.rcfg_write     = wr_q;
  assign rcfg.rcfg_read      = rd_q;
  assign kernel_resetn       = kres_q;
  assign done                = done_q;
  assign error               = error_q;

endmodule

// File: doc/kernel_pll_reconfig_sequencer.md
KERNEL_PLL_RECONFIG_SEQUENCER -- requirements
Module: kernel_pll_reconfig_sequencer

Interface
REQ-001 SHALL have parameter NUM_CLOCKS, default 2: PLL output counters C0..C(NUM_CLOCKS-1); legal range 1..18.
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 1000000: maximum cycles spent in POLL plus WAIT_LOCK.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 16: consecutive locked cycles required before kernel reset release.
REQ-004 clk  in  1  sole clock; all logic is synchronous to clk.
REQ-005 resetn  in  1  asynchronous, active-low reset.
REQ-006 start_valid  in  1  request to reprogram the PLL with the prof_* profile.
REQ-007 start_ready  out  1  high only in IDLE.
REQ-008 prof_n / prof_m  in  18 each  {odd, bypass, hi[7:0], lo[7:0]}.
REQ-009 prof_frac  in  32  M fractional value.
REQ-010 prof_c  in  18*NUM_CLOCKS  slice i = bits [18i+17:18i], same format as prof_n.
REQ-011 rcfg_address  out  6  reconfig IP word address.
REQ-012 rcfg_write / rcfg_read  out  1 each  reconfig IP write and read strobes.
REQ-013 rcfg_writedata  out  32  reconfig IP write data.
REQ-014 rcfg_readdata  in  32  reconfig IP read data.
REQ-015 rcfg_waitrequest  in  1  reconfig IP wait request.
REQ-016 pll_locked  in  1  asynchronous lock from PLL.
REQ-017 kernel_resetn  out  1  active-low reset to kernel clock domain consumers.
REQ-018 busy  out  1  high when not in IDLE.
REQ-019 done  out  1  one-cycle pulse at the end of a sequence.
REQ-020 error  out  1  sticky timeout flag.

Function
REQ-021 SHALL synchronise pll_locked through 2 flops to produce lk; stab_cnt counts consecutive lk-high cycles, saturates at SETTLE_CYCLES, and clears when lk is low.
REQ-022 SHALL implement states IDLE, MODE, WR_N, WR_M, WR_FRAC, WR_C, START, POLL, WAIT_LOCK, in that order.
REQ-023 Handshake: when start_valid and start_ready are both high in cycle T, SHALL latch all prof_* inputs, clear error, and enter MODE at T+1.
REQ-024 Bus writes: address, data and rcfg_write SHALL be held stable until a cycle in which rcfg_waitrequest is low; that cycle completes the write, and the FSM advances on the next edge.
REQ-025 Write sequence:
- MODE: addr 0, data 1.
- WR_N: addr 3, data {14'b0, n}.
- WR_M: addr 4, data {14'b0, m}.
- WR_FRAC: addr 7, data frac.
- WR_C: addr 5, data {9'b0, i[4:0], c_i}, for i = 0..NUM_CLOCKS-1 in order, index incremented per completed write.
- START: addr 2, data 1.
REQ-026 POLL: SHALL read addr 1, with rcfg_read held until waitrequest is low. If rcfg_readdata[0] = 1 in the completing cycle, go to WAIT_LOCK; otherwise deassert read for one cycle and re-issue.
REQ-027 On entry to WAIT_LOCK, SHALL clear stab_cnt. Leave to IDLE with a done pulse once stab_cnt reaches SETTLE_CYCLES.
REQ-028 Timeout counter: SHALL clear on entering POLL and increment each cycle in POLL and WAIT_LOCK.
- Reaching LOCK_TIMEOUT: set error, pulse done, return to IDLE.
- Any outstanding read is dropped.
REQ-029 kernel_resetn SHALL equal (state==IDLE && stab_cnt==SETTLE_CYCLES) and SHALL be registered.
- Lock loss in IDLE drops kernel_resetn one cycle after lk falls.
REQ-030 start_valid outside IDLE SHALL be ignored and not queued.
- Start and lk falling in the same IDLE cycle: start is accepted.
REQ-031 rcfg_read and rcfg_write SHALL never be high in the same cycle.

Reset
REQ-032 On resetn low, SHALL asynchronously clear:
- state = IDLE;
- rcfg_address, rcfg_write, rcfg_read, rcfg_writedata = 0;
- busy, done, error, kernel_resetn = 0;
- stab_cnt, timeout counter, C index = 0;
- synchroniser = 0.
REQ-033 Reset mid-sequence SHALL abort immediately with no further bus activity. A new sequence requires a fresh start handshake.
REQ-034 After reset release, kernel_resetn SHALL rise only once lk has been high for SETTLE_CYCLES consecutive cycles.

Verification
REQ-035 Nominal: NUM_CLOCKS=2, waitrequest=0, status=1 on first read, start at T.
- Writes at T+1..T+7: addresses 0,3,4,7,5,5,2.
- Read at T+8.
- PLL lock held low then high; done plus kernel_resetn rise exactly SETTLE_CYCLES+2 cycles after pll_locked rises.
REQ-036 Backpressure: waitrequest=1 for 3 cycles on the WR_M write.
- Address 4 and its data held for 4 cycles.
- No skipped or duplicated writes.
REQ-037 Timeout: LOCK_TIMEOUT=100, pll_locked held low.
- error=1, done pulse exactly 100 cycles after POLL entry, kernel_resetn=0, start_ready=1.
REQ-038 Mid-sequence reset: resetn low during WR_C (i=1).
- All outputs 0 in the same cycle.
- No rcfg_write until the next start.
REQ-039 IDLE lock loss: pll_locked low 5 cycles after done.
- kernel_resetn=0 from sync+1.
- kernel_resetn returns high SETTLE_CYCLES after relock.
- start_valid while busy is ignored.
